// File: rtl/deserializer8.sv
//------------------------------------------------------------------------------
// deserializer8
//   Reassembles 8-bit words from a one-bit-per-cycle valid/ready stream,
//   with a one-word output holding register.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module deserializer8 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_sync,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [2:0] bit_count,
    output logic       sync_err
);

    logic [2:0] r_bit_count;
    logic [7:0] r_asm;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_sync_err;

    logic       w_accept;
    logic       w_drain;
    logic       w_complete;
    logic [2:0] w_idx;
    logic [2:0] w_pos;
    logic [7:0] w_base;
    logic [7:0] w_bit_mask;
    logic [7:0] w_new_bit;
    logic [7:0] w_next_asm;

    // Only the completing bit has to wait for room in the holding register.
    assign in_ready   = !((r_bit_count == 3'd7) && r_out_valid && !out_ready);

    assign w_accept   = in_valid && in_ready;
    assign w_drain    = r_out_valid && out_ready;
    assign w_idx      = in_sync ? 3'd0 : r_bit_count;
    assign w_pos      = MSB_FIRST ? (3'd7 - w_idx) : w_idx;
    assign w_complete = w_accept && (w_idx == 3'd7);

    // A sync bit restarts the word, so stale partial bits are dropped.
    assign w_base     = in_sync ? 8'h00 : r_asm;
    assign w_bit_mask = 8'd1 << w_pos;
    assign w_new_bit  = in_bit ? w_bit_mask : 8'h00;
    assign w_next_asm = (w_base & ~w_bit_mask) | w_new_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_count <= 3'd0;
            r_asm       <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_sync_err <= w_accept && in_sync && (r_bit_count != 3'd0);

            if (w_accept) begin
                if (w_complete) begin
                    r_asm       <= 8'h00;
                    r_bit_count <= 3'd0;
                    r_out_data  <= w_next_asm;
                    r_out_valid <= 1'b1;
                end else begin
                    r_asm       <= w_next_asm;
                    r_bit_count <= w_idx + 3'd1;
                end
            end

            if (w_drain && !w_complete) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign bit_count = r_bit_count;
    assign sync_err  = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_deserializer8.sv
//------------------------------------------------------------------------------
// tb_deserializer8
//   Self-checking bench for deserializer8 (LSB-first and MSB-first instances).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_deserializer8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       in_sync;
    logic       out_ready;

    logic       rdy_l, ov_l, se_l;
    logic [7:0] od_l;
    logic [2:0] bc_l;
    logic       rdy_m, ov_m, se_m;
    logic [7:0] od_m;
    logic [2:0] bc_m;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending bits in arrival order plus the output slot.
    bit         q[$];
    bit         m_valid;
    logic [7:0] m_data_l;
    logic [7:0] m_data_m;
    bit         m_serr;

    always #5 clk = ~clk;

    deserializer8 #(.MSB_FIRST(1'b0)) u_lsb (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_l),
        .in_bit(in_bit), .in_sync(in_sync), .out_valid(ov_l), .out_ready(out_ready),
        .out_data(od_l), .bit_count(bc_l), .sync_err(se_l)
    );

    deserializer8 #(.MSB_FIRST(1'b1)) u_msb (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
        .in_bit(in_bit), .in_sync(in_sync), .out_valid(ov_m), .out_ready(out_ready),
        .out_data(od_m), .bit_count(bc_m), .sync_err(se_m)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] word_of(input bit msb);
        logic [7:0] w = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (q[k]) w = w + (msb ? (8'd1 << (7 - k)) : (8'd1 << k));
        end
        return w;
    endfunction

    task automatic compare_state();
        chk("bit_count_l", {5'd0, bc_l}, 8'(q.size()));
        chk("bit_count_m", {5'd0, bc_m}, 8'(q.size()));
        chk("out_valid_l", {7'd0, ov_l}, {7'd0, m_valid});
        chk("out_valid_m", {7'd0, ov_m}, {7'd0, m_valid});
        chk("out_data_l", od_l, m_data_l);
        chk("out_data_m", od_m, m_data_m);
        chk("sync_err_l", {7'd0, se_l}, {7'd0, m_serr});
        chk("sync_err_m", {7'd0, se_m}, {7'd0, m_serr});
    endtask

    // One clock cycle: drive, check in_ready, advance model and DUT, compare.
    task automatic cyc(input bit v, input bit b, input bit s, input bit ordy);
        bit exp_rdy, acc, drain, done;
        in_valid = v; in_bit = b; in_sync = s; out_ready = ordy;
        #1;
        exp_rdy = !(q.size() == 7 && m_valid && !ordy);
        chk("in_ready_l", {7'd0, rdy_l}, {7'd0, exp_rdy});
        chk("in_ready_m", {7'd0, rdy_m}, {7'd0, exp_rdy});
        acc   = v && exp_rdy;
        drain = m_valid && ordy;
        done  = 1'b0;
        m_serr = 1'b0;
        if (acc) begin
            if (s) begin
                if (q.size() != 0) m_serr = 1'b1;
                q.delete();
            end
            q.push_back(b);
            if (q.size() == 8) begin
                m_data_l = word_of(1'b0);
                m_data_m = word_of(1'b1);
                m_valid  = 1'b1;
                q.delete();
                done = 1'b1;
            end
        end
        if (drain && !done) m_valid = 1'b0;
        @(posedge clk);
        #1;
        compare_state();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sync = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_valid = 1'b0; m_data_l = 8'h00; m_data_m = 8'h00; m_serr = 1'b0;
        compare_state();
        chk("reset_in_ready", {7'd0, rdy_l}, 8'd1);
    endtask

    task automatic send_word(input logic [7:0] w, input bit ordy);
        for (int k = 0; k < 8; k++) cyc(1'b1, w[k], k == 0, ordy);
    endtask

    typedef struct {
        bit         v, b, s, ordy;
        logic [2:0] bc;
        bit         ov;
        logic [7:0] dl, dm;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 1, 1, 1, 3'd1, 0, 8'h00, 8'h00};
        tbl[1] = '{1, 0, 0, 1, 3'd2, 0, 8'h00, 8'h00};
        tbl[2] = '{1, 1, 0, 1, 3'd3, 0, 8'h00, 8'h00};
        tbl[3] = '{1, 1, 0, 1, 3'd4, 0, 8'h00, 8'h00};
        tbl[4] = '{1, 0, 0, 1, 3'd5, 0, 8'h00, 8'h00};
        tbl[5] = '{1, 0, 0, 1, 3'd6, 0, 8'h00, 8'h00};
        tbl[6] = '{1, 1, 0, 1, 3'd7, 0, 8'h00, 8'h00};
        tbl[7] = '{1, 0, 0, 1, 3'd0, 1, 8'h4D, 8'hB2};

        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sync = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic word, both bit orders, against fixed expectations.
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].ordy);
            chk("tbl_bit_count", {5'd0, bc_l}, {5'd0, tbl[i].bc});
            chk("tbl_out_valid", {7'd0, ov_l}, {7'd0, tbl[i].ov});
            chk("tbl_data_lsb", od_l, tbl[i].dl);
            chk("tbl_data_msb", od_m, tbl[i].dm);
            chk("tbl_sync_err", {7'd0, se_l}, 8'd0);
        end

        // Back-to-back words with the consumer always ready.
        send_word(8'hA5, 1'b1);
        chk("stream_a5", od_l, 8'hA5);
        chk("stream_a5_valid", {7'd0, ov_l}, 8'd1);
        send_word(8'h3C, 1'b1);
        chk("stream_3c", od_l, 8'h3C);
        chk("stream_ready", {7'd0, rdy_l}, 8'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("stream_drained", {7'd0, ov_l}, 8'd0);

        // Backpressure: word FF pending, 7 bits of 01 buffered, 8th waits.
        send_word(8'hFF, 1'b0);
        for (int k = 0; k < 7; k++) cyc(1'b1, k == 0, k == 0, 1'b0);
        chk("bp_bit_count", {5'd0, bc_l}, 8'd7);
        chk("bp_hold_data", od_l, 8'hFF);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_stalled_count", {5'd0, bc_l}, 8'd7);
        chk("bp_stalled_data", od_l, 8'hFF);
        #1;
        chk("bp_in_ready_low", {7'd0, rdy_l}, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("bp_new_word", od_l, 8'h01);
        chk("bp_new_word_m", od_m, 8'h80);
        chk("bp_valid_kept", {7'd0, ov_l}, 8'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Resync mid-word.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, k == 0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("resync_pulse", {7'd0, se_l}, 8'd1);
        chk("resync_count", {5'd0, bc_l}, 8'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("resync_pulse_end", {7'd0, se_l}, 8'd0);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("resync_word", od_l, 8'hFE);

        // Reset in the middle of a word.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, k == 0, 1'b0);
        do_reset();
        chk("midreset_data", od_l, 8'h00);
        send_word(8'h96, 1'b1);
        chk("midreset_word", od_l, 8'h96);
        chk("midreset_word_m", od_m, 8'h69);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                $urandom_range(15, 0) == 0, $urandom_range(1, 0) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
